// File: rtl/jk_seq_ctrl.sv
// ---------------------------------------------------------------------------
// jk_seq_ctrl
//   Command-driven sequencer for a W-bit register made of JK flip-flop cells.
//   Host commands (NOP, CLEAR, LOAD, TOGGLE, STEP_UP/DN, RUN_UP/DN) are
//   decoded into per-bit J/K. The register itself lives here as an array of
//   JK cells, and the same J/K are exported so an external JK bank can
//   shadow it.
//
// Ports
//   i_clk        system clock, all state changes on posedge
//   i_rst        synchronous active-high reset
//   i_cmd_valid  command present
//   o_cmd_ready  command can be accepted (not busy)
//   i_cmd_op     3'b000 NOP, 001 CLEAR, 010 LOAD, 011 TOGGLE,
//                100 RUN_UP, 101 RUN_DN, 110 STEP_UP, 111 STEP_DN
//   i_cmd_data   LOAD value / TOGGLE mask / RUN target
//   i_abort      ends a RUN_UP/RUN_DN early (ignored in other states)
//   o_j, o_k     per-bit J/K applied this cycle
//   o_q          register state
//   o_busy       sequencer not idle
//   o_done       one-cycle pulse after a command completes
// ---------------------------------------------------------------------------

// Single register bit: JK=00 hold, 01 clear, 10 set, 11 toggle.
module jk_seq_cell (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            case ({i_j, i_k})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;
endmodule

module jk_seq_ctrl #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [2:0]   i_cmd_op,
    input  logic [W-1:0] i_cmd_data,
    input  logic         i_abort,
    output logic [W-1:0] o_j,
    output logic [W-1:0] o_k,
    output logic [W-1:0] o_q,
    output logic         o_busy,
    output logic         o_done
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_CLEAR   = 3'b001;
    localparam logic [2:0] OP_LOAD    = 3'b010;
    localparam logic [2:0] OP_TOGGLE  = 3'b011;
    localparam logic [2:0] OP_RUN_UP  = 3'b100;
    localparam logic [2:0] OP_RUN_DN  = 3'b101;
    localparam logic [2:0] OP_STEP_UP = 3'b110;
    localparam logic [2:0] OP_STEP_DN = 3'b111;

    logic [1:0]   r_state;
    logic [2:0]   r_op;
    logic [W-1:0] r_data;
    logic         r_done;

    logic [W-1:0] w_q;
    logic [W-1:0] w_j;
    logic [W-1:0] w_k;
    logic [W-1:0] w_up;
    logic [W-1:0] w_dn;
    logic         w_match;
    logic         w_accept;
    logic         w_is_run;

    // Counter toggle masks: bit i flips when all lower bits are 1 (up)
    // or all lower bits are 0 (down). Bit 0 always flips.
    assign w_up[0] = 1'b1;
    assign w_dn[0] = 1'b1;
    for (genvar gi = 1; gi < W; gi++) begin : g_carry
        assign w_up[gi] = w_up[gi-1] &  w_q[gi-1];
        assign w_dn[gi] = w_dn[gi-1] & ~w_q[gi-1];
    end

    assign w_match  = (w_q == r_data);
    assign w_accept = i_cmd_valid && (r_state == ST_IDLE);
    // RUN_UP / RUN_DN are the only 10x opcodes.
    assign w_is_run = i_cmd_op[2] && !i_cmd_op[1];

    always_comb begin
        w_j = '0;
        w_k = '0;
        case (r_state)
            ST_EXEC: begin
                case (r_op)
                    OP_CLEAR: begin
                        w_j = '0;
                        w_k = '1;
                    end
                    OP_LOAD: begin
                        w_j = r_data;
                        w_k = ~r_data;
                    end
                    OP_TOGGLE: begin
                        w_j = r_data;
                        w_k = r_data;
                    end
                    OP_STEP_UP: begin
                        w_j = w_up;
                        w_k = w_up;
                    end
                    OP_STEP_DN: begin
                        w_j = w_dn;
                        w_k = w_dn;
                    end
                    default: begin
                        w_j = '0;
                        w_k = '0;
                    end
                endcase
            end
            ST_RUN: begin
                // Abort wins over the target check; both leave q untouched.
                if (!i_abort && !w_match) begin
                    w_j = (r_op == OP_RUN_DN) ? w_dn : w_up;
                    w_k = (r_op == OP_RUN_DN) ? w_dn : w_up;
                end
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= i_cmd_op;
                        r_data  <= i_cmd_data;
                        r_state <= w_is_run ? ST_RUN : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
                ST_RUN: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_match) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar gb = 0; gb < W; gb++) begin : g_bit
        jk_seq_cell u_cell (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_j   (w_j[gb]),
            .i_k   (w_k[gb]),
            .o_q   (w_q[gb])
        );
    end

    assign o_j         = w_j;
    assign o_k         = w_k;
    assign o_q         = w_q;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_done      = r_done;
endmodule

// File: tb/tb_jk_seq_ctrl.sv
module tb_jk_seq_ctrl;
    localparam int W = 4;
    localparam int M = 1 << W;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_CLEAR   = 3'b001;
    localparam logic [2:0] OP_LOAD    = 3'b010;
    localparam logic [2:0] OP_TOGGLE  = 3'b011;
    localparam logic [2:0] OP_RUN_UP  = 3'b100;
    localparam logic [2:0] OP_RUN_DN  = 3'b101;
    localparam logic [2:0] OP_STEP_UP = 3'b110;
    localparam logic [2:0] OP_STEP_DN = 3'b111;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid = 1'b0;
    logic         abort = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] data = '0;
    logic         ready, busy, done;
    logic [W-1:0] j, k, q;

    int n_chk  = 0;
    int n_fail = 0;
    int m_q    = 0;   // reference register value

    jk_seq_ctrl #(.W(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (valid),
        .o_cmd_ready (ready),
        .i_cmd_op    (op),
        .i_cmd_data  (data),
        .i_abort     (abort),
        .o_j         (j),
        .o_k         (k),
        .o_q         (q),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Bits that change on +1 / -1 modulo 2^W.
    function automatic int up_pat(input int v);
        return ((v + 1) ^ v) & (M - 1);
    endfunction
    function automatic int dn_pat(input int v);
        return ((v - 1) ^ v) & (M - 1);
    endfunction

    // Garbage on the command port while busy; must never be accepted.
    task automatic junk();
        valid = 1'($urandom);
        op    = 3'($urandom);
        data  = W'($urandom);
    endtask

    // Idle cycle with a command offered; ends just after the accepting edge.
    task automatic offer(input logic [2:0] o, input int d);
        valid = 1'b1;
        op    = o;
        data  = W'(d);
        #1;
        chk("idle_ready", 32'(ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_j", 32'(j), 0);
        chk("idle_k", 32'(k), 0);
        chk("idle_q", 32'(q), 32'(m_q));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b1;
        op    = OP_LOAD;
        data  = '1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_q", 32'(q), 0);
            chk("rst_j", 32'(j), 0);
            chk("rst_k", 32'(k), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ready", 32'(ready), 1);
            chk("rst_done", 32'(done), 0);
        end
        rst   = 1'b0;
        valid = 1'b0;
        abort = 1'b0;
        m_q   = 0;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_q", 32'(q), 0);
    endtask

    task automatic single(input logic [2:0] o, input int d);
        int ej, ek, nq;
        abort = 1'($urandom);
        offer(o, d);
        junk();
        abort = 1'($urandom);
        #1;
        d  = d & (M - 1);
        ej = 0; ek = 0; nq = m_q;
        case (o)
            OP_CLEAR:   begin ek = M - 1; nq = 0; end
            OP_LOAD:    begin ej = d; ek = (~d) & (M - 1); nq = d; end
            OP_TOGGLE:  begin ej = d; ek = d; nq = m_q ^ d; end
            OP_STEP_UP: begin ej = up_pat(m_q); ek = ej; nq = (m_q + 1) % M; end
            OP_STEP_DN: begin ej = dn_pat(m_q); ek = ej; nq = (m_q + M - 1) % M; end
            default:    begin end
        endcase
        chk("exec_busy", 32'(busy), 1);
        chk("exec_ready", 32'(ready), 0);
        chk("exec_done", 32'(done), 0);
        chk("exec_j", 32'(j), 32'(ej));
        chk("exec_k", 32'(k), 32'(ek));
        @(posedge clk); #1;
        valid = 1'b0;
        abort = 1'b0;
        m_q = nq;
        chk("exec_q", 32'(q), 32'(m_q));
        chk("exec_done_pulse", 32'(done), 1);
        chk("exec_idle", 32'(busy), 0);
    endtask

    // abort_step < 0: no abort; otherwise abort in that RUN cycle.
    task automatic run(input logic [2:0] o, input int tgt, input int abort_step);
        int  cyc, exp_cyc, p;
        bit  fin, aborted;
        bit  up;
        up = (o == OP_RUN_UP);
        tgt = tgt & (M - 1);
        abort = 1'b0;
        offer(o, tgt);
        exp_cyc = (up ? (tgt - m_q + M) : (m_q - tgt + M)) % M + 1;
        cyc = 0; fin = 0; aborted = 0;
        while (!fin && cyc < 40) begin
            junk();
            abort = (cyc == abort_step);
            #1;
            chk("run_busy", 32'(busy), 1);
            chk("run_ready", 32'(ready), 0);
            chk("run_done_low", 32'(done), 0);
            chk("run_q", 32'(q), 32'(m_q));
            if (abort) begin
                chk("abort_j", 32'(j), 0);
                chk("abort_k", 32'(k), 0);
                @(posedge clk); #1;
                abort = 1'b0;
                valid = 1'b0;
                chk("abort_q_hold", 32'(q), 32'(m_q));
                chk("abort_ready", 32'(ready), 1);
                chk("abort_no_done", 32'(done), 0);
                fin = 1; aborted = 1;
            end else if (m_q == tgt) begin
                chk("match_j", 32'(j), 0);
                chk("match_k", 32'(k), 0);
                @(posedge clk); #1;
                valid = 1'b0;
                chk("match_q", 32'(q), 32'(m_q));
                chk("match_done", 32'(done), 1);
                chk("match_idle", 32'(busy), 0);
                fin = 1;
            end else begin
                p = up ? up_pat(m_q) : dn_pat(m_q);
                chk("count_j", 32'(j), 32'(p));
                chk("count_k", 32'(k), 32'(p));
                @(posedge clk); #1;
                m_q = up ? (m_q + 1) % M : (m_q + M - 1) % M;
            end
            cyc++;
        end
        if (!fin) chk("run_timeout", 0, 1);
        else if (!aborted) chk("run_cycles", 32'(cyc), 32'(exp_cyc));
    endtask

    // RUN_UP interrupted by reset after 'steps' count cycles.
    task automatic run_rst(input int tgt, input int steps);
        offer(OP_RUN_UP, tgt);
        valid = 1'b0;
        for (int s = 0; s < steps; s++) begin
            #1;
            chk("rr_q", 32'(q), 32'(m_q));
            @(posedge clk); #1;
            m_q = (m_q + 1) % M;
        end
        chk("rr_q_before", 32'(q), 32'(m_q));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_q = 0;
        chk("rr_q", 32'(q), 0);
        chk("rr_busy", 32'(busy), 0);
        chk("rr_done", 32'(done), 0);
    endtask

    initial begin
        int r, t, a;
        logic [2:0] sop;
        do_reset();
        // directed scenarios
        single(OP_LOAD, 'hA);
        single(OP_TOGGLE, 'h5);
        single(OP_STEP_UP, 0);
        single(OP_STEP_DN, 0);
        single(OP_LOAD, 'h3);
        run(OP_RUN_UP, 'h7, -1);
        single(OP_LOAD, 'h8);
        run(OP_RUN_DN, 'h2, 2);
        single(OP_LOAD, 'hE);
        run(OP_RUN_UP, 'h1, -1);
        run(OP_RUN_DN, 'h1, -1);
        single(OP_LOAD, 'h4);
        run(OP_RUN_UP, 'h6, 2);
        single(OP_LOAD, 'h2);
        run_rst('hC, 3);
        single(OP_LOAD, 'h9);
        single(OP_CLEAR, 0);
        single(OP_NOP, 0);
        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                do_reset();
            end else if (r < 8) begin
                t = $urandom_range(0, M - 1);
                a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1;
                run(($urandom_range(0, 1) == 0) ? OP_RUN_UP : OP_RUN_DN, t, a);
            end else begin
                case ($urandom_range(0, 5))
                    0: sop = OP_NOP;
                    1: sop = OP_CLEAR;
                    2: sop = OP_LOAD;
                    3: sop = OP_TOGGLE;
                    4: sop = OP_STEP_UP;
                    default: sop = OP_STEP_DN;
                endcase
                single(sop, $urandom_range(0, M - 1));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
